// File: rtl/fetch_inst_queue_if.sv
// Handshake bundle between IF2, the instruction queue and the ID stage.
// master = fetch/decode side driving lanes and dequeue count, slave = the queue.
interface fetch_inst_queue_if #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned FETCH_W = 2,
  parameter int unsigned ISSUE_W = 2,
  parameter int unsigned DW      = 32
);
  logic                           flush;
  logic [FETCH_W-1:0]             i_valid;
  logic [FETCH_W*DW-1:0]          i_pc;
  logic [FETCH_W*DW-1:0]          i_ir;
  logic [$clog2(ISSUE_W+1)-1:0]   i_deq_num;
  logic                           o_full;
  logic [ISSUE_W-1:0]             o_valid;
  logic [ISSUE_W*DW-1:0]          o_pc;
  logic [ISSUE_W*DW-1:0]          o_ir;
  logic [$clog2(DEPTH+1)-1:0]     o_count;

  modport master (
    output flush, i_valid, i_pc, i_ir, i_deq_num,
    input  o_full, o_valid, o_pc, o_ir, o_count
  );

  modport slave (
    input  flush, i_valid, i_pc, i_ir, i_deq_num,
    output o_full, o_valid, o_pc, o_ir, o_count
  );
endinterface

// File: rtl/fetch_inst_queue.sv
// Circular instruction queue between IF2 and ID: compacts FETCH_W valid lanes on entry,
// presents up to ISSUE_W head entries, dequeues a variable count, flushes on redirect.
module fetch_inst_queue #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned FETCH_W = 2,
  parameter int unsigned ISSUE_W = 2,
  parameter int unsigned DW      = 32
) (
  input logic                clk,
  input logic                rst,
  fetch_inst_queue_if.slave  bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DW-1:0] pc_mem_q [DEPTH];
  logic [DW-1:0] pc_mem_d [DEPTH];
  logic [DW-1:0] ir_mem_q [DEPTH];
  logic [DW-1:0] ir_mem_d [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          full;
  logic          enq_en;
  logic [CW-1:0] nenq;
  logic [CW-1:0] deq_req;
  logic [CW-1:0] ndeq;
  logic [PW-1:0] rd_slot;

  // Full is judged on registered occupancy only, so fetch never sees a comb path.
  always_comb begin
    full = (CW'(DEPTH) - count_q) < CW'(FETCH_W);
  end

  always_comb begin
    pc_mem_d = pc_mem_q;
    ir_mem_d = ir_mem_q;
    wr_ptr_d = wr_ptr_q;
    nenq     = '0;
    enq_en   = !full && !bus.flush;

    // Valid lanes are packed into consecutive slots; invalid lanes leave no hole.
    for (int k = 0; k < FETCH_W; k++) begin
      if (enq_en && bus.i_valid[k]) begin
        pc_mem_d[wr_ptr_d] = bus.i_pc[k*DW +: DW];
        ir_mem_d[wr_ptr_d] = bus.i_ir[k*DW +: DW];
        wr_ptr_d           = wr_ptr_d + PW'(1);
        nenq               = nenq + CW'(1);
      end
    end

    deq_req = CW'(bus.i_deq_num);
    if (deq_req > CW'(ISSUE_W)) begin
      deq_req = CW'(ISSUE_W);
    end
    ndeq = (deq_req > count_q) ? count_q : deq_req;

    rd_ptr_d = rd_ptr_q + PW'(ndeq);
    count_d  = count_q + nenq - ndeq;

    if (bus.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not cleared by reset or flush.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_mem_q <= pc_mem_d;
      ir_mem_q <= ir_mem_d;
    end
  end

  always_comb begin
    bus.o_valid = '0;
    bus.o_pc    = '0;
    bus.o_ir    = '0;
    rd_slot     = rd_ptr_q;
    for (int k = 0; k < ISSUE_W; k++) begin
      rd_slot        = rd_ptr_q + PW'(k);
      bus.o_valid[k] = count_q > CW'(k);
      if (bus.o_valid[k]) begin
        bus.o_pc[k*DW +: DW] = pc_mem_q[rd_slot];
        bus.o_ir[k*DW +: DW] = ir_mem_q[rd_slot];
      end
    end
    bus.o_count = count_q;
    bus.o_full  = full;
  end
endmodule

// File: tb/tb_fetch_inst_queue.sv
// Directed bench for fetch_inst_queue; a queue-based model is compared on every cycle
// and literal expectations pin the key scenarios.
module tb_fetch_inst_queue;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned FETCH_W = 2;
  localparam int unsigned ISSUE_W = 2;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
  } ent_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  bit   model_on;
  ent_t mq[$];
  int   n_deq;
  bit   m_full;
  logic [31:0] pcn;

  fetch_inst_queue_if #(.DEPTH(DEPTH), .FETCH_W(FETCH_W), .ISSUE_W(ISSUE_W), .DW(32)) bus ();

  fetch_inst_queue #(.DEPTH(DEPTH), .FETCH_W(FETCH_W), .ISSUE_W(ISSUE_W), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the queue contents as a plain FIFO of entries.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      model_on = 1'b1;
    end else if (bus.flush) begin
      mq.delete();
    end else begin
      m_full = (DEPTH - mq.size()) < FETCH_W;
      n_deq  = int'(bus.i_deq_num);
      if (n_deq > ISSUE_W) n_deq = ISSUE_W;
      if (n_deq > mq.size()) n_deq = mq.size();
      for (int i = 0; i < n_deq; i++) void'(mq.pop_front());
      if (!m_full) begin
        for (int k = 0; k < FETCH_W; k++) begin
          if (bus.i_valid[k]) mq.push_back('{pc: bus.i_pc[k*32 +: 32], ir: bus.i_ir[k*32 +: 32]});
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("m_count", 32'(bus.o_count), 32'(mq.size()));
      chk("m_full", 32'(bus.o_full), 32'((DEPTH - mq.size()) < FETCH_W));
      for (int k = 0; k < ISSUE_W; k++) begin
        chk("m_valid", 32'(bus.o_valid[k]), 32'(k < mq.size()));
        chk("m_pc", bus.o_pc[k*32 +: 32], (k < mq.size()) ? mq[k].pc : 32'h0);
        chk("m_ir", bus.o_ir[k*32 +: 32], (k < mq.size()) ? mq[k].ir : 32'h0);
      end
    end
  end

  task automatic cyc(input logic r, input logic fl, input logic [1:0] v,
                     input logic [31:0] p0, input logic [31:0] p1, input logic [1:0] dn);
    rst           = r;
    bus.flush     = fl;
    bus.i_valid   = v;
    bus.i_pc      = {p1, p0};
    bus.i_ir      = {~p1, ~p0};
    bus.i_deq_num = dn;
    @(negedge clk);
  endtask

  task automatic enq2(input logic [1:0] dn);
    cyc(1'b0, 1'b0, 2'b11, pcn, pcn + 32'd4, dn);
    pcn = pcn + 32'd8;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    model_on = 1'b0;

    cyc(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 2'd0);
    cyc(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 2'd0);
    chk("rst_count", 32'(bus.o_count), 32'd0);
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_full", 32'(bus.o_full), 32'd0);

    // Basic flow.
    cyc(1'b0, 1'b0, 2'b11, 32'h1c000, 32'h1c004, 2'd0);
    chk("basic_valid", 32'(bus.o_valid), 32'd3);
    chk("basic_pc0", bus.o_pc[31:0], 32'h1c000);
    chk("basic_pc1", bus.o_pc[63:32], 32'h1c004);
    chk("basic_ir0", bus.o_ir[31:0], ~32'h1c000);
    chk("basic_count", 32'(bus.o_count), 32'd2);

    // Compaction of a lone upper lane.
    cyc(1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 2'd0);
    cyc(1'b0, 1'b0, 2'b10, 32'hbad0, 32'h1c008, 2'd0);
    chk("cmp_valid", 32'(bus.o_valid), 32'd1);
    chk("cmp_pc0", bus.o_pc[31:0], 32'h1c008);
    chk("cmp_pc1", bus.o_pc[63:32], 32'h0);
    chk("cmp_count", 32'(bus.o_count), 32'd1);

    // Fill to full, then backpressure.
    cyc(1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 2'd0);
    pcn = 32'h1c010;
    for (int i = 0; i < 7; i++) enq2(2'd0);
    chk("fill14_count", 32'(bus.o_count), 32'd14);
    chk("fill14_full", 32'(bus.o_full), 32'd0);
    enq2(2'd0);
    chk("full_count", 32'(bus.o_count), 32'd16);
    chk("full_full", 32'(bus.o_full), 32'd1);
    cyc(1'b0, 1'b0, 2'b11, 32'hdead0000, 32'hdead0004, 2'd0);
    chk("bp_count", 32'(bus.o_count), 32'd16);
    chk("bp_pc0", bus.o_pc[31:0], 32'h1c010);
    cyc(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 2'd1);
    chk("deq1_count", 32'(bus.o_count), 32'd15);
    chk("deq1_full", 32'(bus.o_full), 32'd1);
    chk("deq1_pc0", bus.o_pc[31:0], 32'h1c014);

    // Drain to 5, then steady 2-in/2-out across the wrap.
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 2'd2);
    chk("drain_count", 32'(bus.o_count), 32'd5);
    chk("drain_pc0", bus.o_pc[31:0], 32'h1c03c);
    for (int i = 0; i < 20; i++) begin
      enq2(2'd2);
      chk("wrap_count", 32'(bus.o_count), 32'd5);
      chk("wrap_pc0", bus.o_pc[31:0], 32'h1c03c + 32'(8 * (i + 1)));
      chk("wrap_pc1", bus.o_pc[63:32], 32'h1c040 + 32'(8 * (i + 1)));
    end

    // Over-dequeue clamps.
    cyc(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 2'd3);
    chk("clamp3_count", 32'(bus.o_count), 32'd3);
    cyc(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 2'd2);
    chk("clamp_c1", 32'(bus.o_count), 32'd1);
    cyc(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 2'd2);
    chk("under_count", 32'(bus.o_count), 32'd0);
    chk("under_valid", 32'(bus.o_valid), 32'd0);

    // Flush with concurrent enqueue/dequeue, then flush while full.
    for (int i = 0; i < 5; i++) enq2(2'd0);
    chk("c10_count", 32'(bus.o_count), 32'd10);
    cyc(1'b0, 1'b1, 2'b11, 32'h1234, 32'h5678, 2'd2);
    chk("fl_count", 32'(bus.o_count), 32'd0);
    chk("fl_valid", 32'(bus.o_valid), 32'd0);
    chk("fl_full", 32'(bus.o_full), 32'd0);
    for (int i = 0; i < 8; i++) enq2(2'd0);
    chk("fl2_pre_full", 32'(bus.o_full), 32'd1);
    cyc(1'b0, 1'b1, 2'b11, 32'h1234, 32'h5678, 2'd0);
    chk("fl2_count", 32'(bus.o_count), 32'd0);
    chk("fl2_full", 32'(bus.o_full), 32'd0);

    // Reset beats flush/enqueue/dequeue.
    enq2(2'd0);
    enq2(2'd0);
    cyc(1'b1, 1'b1, 2'b11, 32'h1234, 32'h5678, 2'd2);
    chk("rf_count", 32'(bus.o_count), 32'd0);
    chk("rf_valid", 32'(bus.o_valid), 32'd0);
    chk("rf_full", 32'(bus.o_full), 32'd0);
    chk("rf_pc", bus.o_pc[31:0], 32'd0);
    chk("rf_ir", bus.o_ir[63:32], 32'd0);

    cyc(1'b0, 1'b0, 2'b01, 32'h1c100, 32'h0, 2'd0);
    chk("post_pc0", bus.o_pc[31:0], 32'h1c100);
    cyc(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
